// File: rtl/secret_dut.sv
// Width-marshalling demonstration block: one 32-bit running accumulator with a
// combinational bypass mux, plus independent pass-through channels of assorted widths.
module secret_dut (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      accum_in,
    output logic [31:0]      accum_out,
    input  logic             accum_bypass,
    output logic [31:0]      accum_bypass_out,
    input  logic             s1_in,
    output logic             s1_out,
    input  logic [1:0]       s2_in,
    output logic [1:0]       s2_out,
    input  logic [7:0]       s8_in,
    output logic [7:0]       s8_out,
    input  logic [32:0]      s33_in,
    output logic [32:0]      s33_out,
    input  logic [63:0]      s64_in,
    output logic [63:0]      s64_out,
    input  logic [64:0]      s65_in,
    output logic [64:0]      s65_out,
    input  logic [128:0]     s129_in,
    output logic [128:0]     s129_out,
    input  logic [3:0][31:0] s4x32_in,
    output logic [3:0][31:0] s4x32_out
);

    logic [31:0] acc;

    // Modulo-2^32 accumulation; carry-out is intentionally dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= acc + accum_in;
        end
    end

    assign accum_out        = acc;
    assign accum_bypass_out = accum_bypass ? accum_in : acc;

    assign s1_out    = s1_in;
    assign s2_out    = s2_in;
    assign s8_out    = s8_in;
    assign s33_out   = s33_in;
    assign s64_out   = s64_in;
    assign s65_out   = s65_in;
    assign s129_out  = s129_in;
    assign s4x32_out = s4x32_in;

endmodule

// File: tb/tb_secret_dut.sv
// Directed self-checking bench for secret_dut: two instances sharing clock and reset.
module tb_secret_dut;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance a / b accumulator side
    logic [31:0] ain, bin, aout, bout, abyp_out, bbyp_out;
    logic        abyp, bbyp;

    // shared pass-through stimulus, separate outputs per instance
    logic             s1;
    logic [1:0]       s2;
    logic [7:0]       s8;
    logic [32:0]      s33;
    logic [63:0]      s64;
    logic [64:0]      s65;
    logic [128:0]     s129;
    logic [3:0][31:0] s4x32;

    logic             a_s1, b_s1;
    logic [1:0]       a_s2, b_s2;
    logic [7:0]       a_s8, b_s8;
    logic [32:0]      a_s33, b_s33;
    logic [63:0]      a_s64, b_s64;
    logic [64:0]      a_s65, b_s65;
    logic [128:0]     a_s129, b_s129;
    logic [3:0][31:0] a_s4x32, b_s4x32;

    // expected copies of driven pass-through values
    logic             e1;
    logic [1:0]       e2;
    logic [7:0]       e8;
    logic [32:0]      e33;
    logic [63:0]      e64;
    logic [64:0]      e65;
    logic [128:0]     e129;
    logic [127:0]     e4x32;

    logic [31:0] ea, eb;
    int checks = 0;
    int failures = 0;

    secret_dut u_a (
        .clk(clk), .rst_n(rst_n), .accum_in(ain), .accum_out(aout),
        .accum_bypass(abyp), .accum_bypass_out(abyp_out),
        .s1_in(s1), .s1_out(a_s1), .s2_in(s2), .s2_out(a_s2),
        .s8_in(s8), .s8_out(a_s8), .s33_in(s33), .s33_out(a_s33),
        .s64_in(s64), .s64_out(a_s64), .s65_in(s65), .s65_out(a_s65),
        .s129_in(s129), .s129_out(a_s129), .s4x32_in(s4x32), .s4x32_out(a_s4x32)
    );

    secret_dut u_b (
        .clk(clk), .rst_n(rst_n), .accum_in(bin), .accum_out(bout),
        .accum_bypass(bbyp), .accum_bypass_out(bbyp_out),
        .s1_in(s1), .s1_out(b_s1), .s2_in(s2), .s2_out(b_s2),
        .s8_in(s8), .s8_out(b_s8), .s33_in(s33), .s33_out(b_s33),
        .s64_in(s64), .s64_out(b_s64), .s65_in(s65), .s65_out(b_s65),
        .s129_in(s129), .s129_out(b_s129), .s4x32_in(s4x32), .s4x32_out(b_s4x32)
    );

    task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, updating the reference sums from the inputs sampled there.
    task automatic tick();
        if (!rst_n) begin
            ea = '0;
            eb = '0;
        end else begin
            ea = ea + ain;
            eb = eb + bin;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pt(input logic [159:0] r, input logic [127:0] q);
        s1 = r[0];      s2 = r[2:1];     s8 = r[10:3];
        s33 = r[43:11]; s64 = r[127:64]; s65 = r[64:0];
        s129 = r[128:0];
        s4x32 = q;
        e1 = r[0];      e2 = r[2:1];     e8 = r[10:3];
        e33 = r[43:11]; e64 = r[127:64]; e65 = r[64:0];
        e129 = r[128:0];
        e4x32 = q;
    endtask

    task automatic chk_pt(input string tag);
        chk({tag, " s1"},    129'(a_s1),    129'(e1));
        chk({tag, " s2"},    129'(a_s2),    129'(e2));
        chk({tag, " s8"},    129'(a_s8),    129'(e8));
        chk({tag, " s33"},   129'(a_s33),   129'(e33));
        chk({tag, " s64"},   129'(a_s64),   129'(e64));
        chk({tag, " s65"},   129'(a_s65),   129'(e65));
        chk({tag, " s129"},  a_s129,        e129);
        chk({tag, " s4x32"}, 129'(a_s4x32), 129'(e4x32));
        chk({tag, " b_s129"}, b_s129,       e129);
        chk({tag, " b_s4x32"}, 129'(b_s4x32), 129'(e4x32));
    endtask

    initial begin
        logic [31:0] ahand [4];
        logic [31:0] bhand [4];
        logic [31:0] ares  [4];
        logic [31:0] bres  [4];
        ahand = '{32'd0, 32'd5, 32'd10, 32'd15};
        ares  = '{32'd0, 32'd5, 32'd15, 32'd30};
        bhand = '{32'd100, 32'd105, 32'd110, 32'd115};
        bres  = '{32'd100, 32'd205, 32'd315, 32'd430};

        ea = '0; eb = '0;
        rst_n = 1'b0; abyp = 1'b0; bbyp = 1'b0;
        ain = 32'h1234; bin = 32'h1234;
        drive_pt('0, '0);
        #2;

        // reset held for two edges
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("reset accum_out", 129'(aout), 129'(0));
            chk("reset bypass_out", 129'(abyp_out), 129'(0));
            chk("reset b accum_out", 129'(bout), 129'(0));
        end

        // hand-computed accumulation
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ain = ahand[i];
            bin = bhand[i];
            tick();
            chk("accum hand a", 129'(aout), 129'(ares[i]));
            chk("accum hand b", 129'(bout), 129'(bres[i]));
            chk("normal bypass_out", 129'(abyp_out), 129'(ares[i]));
        end

        // ramp from 100 step 5 on a, constant 7 on b
        for (int i = 0; i < 8; i++) begin
            ain = 32'd100 + 32'(5 * i);
            bin = 32'd7;
            tick();
            chk("accum ramp a", 129'(aout), 129'(ea));
            chk("accum ramp b", 129'(bout), 129'(eb));
        end

        // bypass: same-cycle source switch, accumulation continues
        abyp = 1'b1;
        ain = 32'h55;
        #1;
        chk("bypass same cycle", 129'(abyp_out), 129'(32'h55));
        chk("bypass b unaffected", 129'(bbyp_out), 129'(eb));
        tick();
        chk("accum during bypass", 129'(aout), 129'(ea));
        chk("bypass held", 129'(abyp_out), 129'(32'h55));
        ain = 32'h11;
        #1;
        chk("bypass follows in", 129'(abyp_out), 129'(32'h11));
        abyp = 1'b0;
        #1;
        chk("bypass dropped", 129'(abyp_out), 129'(ea));

        // wrap-around
        ain = 32'hFFFF_FFFE - ea;
        tick();
        chk("preload", 129'(aout), 129'(32'hFFFF_FFFE));
        ain = 32'd5;
        tick();
        chk("wrap", 129'(aout), 129'(32'h0000_0003));

        // mid-operation reset; pass-throughs unaffected by reset
        rst_n = 1'b0;
        drive_pt({5{32'hA5C3_0F96}}, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
        tick();
        chk("mid reset", 129'(aout), 129'(0));
        chk("mid reset b", 129'(bout), 129'(0));
        chk_pt("pt in reset");
        rst_n = 1'b1;
        ain = 32'd9;
        tick();
        chk("restart", 129'(aout), 129'(32'd9));
        chk("restart b", 129'(bout), 129'(32'd7));

        // pass-through patterns
        drive_pt('1, '1);
        tick();
        chk_pt("pt ones");
        drive_pt('0, '0);
        tick();
        chk_pt("pt zeros");
        drive_pt('0, {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001});
        s65 = {1'b1, 64'd0};   e65 = {1'b1, 64'd0};
        s129 = {1'b1, 128'd0}; e129 = {1'b1, 128'd0};
        tick();
        chk_pt("pt msb");
        for (int i = 0; i < 6; i++) begin
            drive_pt({$urandom, $urandom, $urandom, $urandom, $urandom},
                     {$urandom, $urandom, $urandom, $urandom});
            tick();
            chk_pt("pt rand");
            chk("pt rand accum", 129'(aout), 129'(ea));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/secret_dut.md
# secret_dut

Protected-IP demonstration block exposing one registered 32-bit accumulator with a combinational bypass, plus a set of width-varied combinational pass-through channels. It sits behind an opaque, library-wrapped boundary. Its purpose is to exercise port marshalling of every width class: 1, 2, 8, 33, 64, 65 and 129 bits, and packed 4x32 arrays. Multiple independent instances may coexist and share no state.

## Interface
Parameters:
- None. All widths are fixed.

Ports:
- `clk`  in  1  Sole clock. All state updates on its rising edge.
- `rst_n`  in  1  Reset. Synchronous and active-low. Sampled on the rising edge of `clk`.
- `accum_in`  in  32  Addend accumulated every cycle.
- `accum_out`  out  32  Registered accumulator value.
- `accum_bypass`  in  1  Selects the source of `accum_bypass_out`.
- `accum_bypass_out`  out  32  Combinational: `accum_in` when `accum_bypass`=1, else `accum_out`.
- `s1_in`/`s1_out`  in/out  1  Pass-through.
- `s2_in`/`s2_out`  in/out  2  Pass-through.
- `s8_in`/`s8_out`  in/out  8  Pass-through.
- `s33_in`/`s33_out`  in/out  33  Pass-through.
- `s64_in`/`s64_out`  in/out  64  Pass-through.
- `s65_in`/`s65_out`  in/out  65  Pass-through.
- `s129_in`/`s129_out`  in/out  129  Pass-through.
- `s4x32_in`/`s4x32_out`  in/out  [3:0][31:0]  Packed-array pass-through. Element order is preserved: element k drives element k.

## Operation
- Accumulator: a 32-bit register `acc`, driven onto `accum_out`.
- On each rising edge of `clk`:
  - If `rst_n`=0: `acc` <= 0.
  - Otherwise: `acc` <= `acc` + `accum_in`.
- Arithmetic is unsigned modulo 2^32. Carry-out is discarded. There is no overflow flag and no saturation.
- `accum_bypass_out` = `accum_bypass` ? `accum_in` : `acc`. This is a pure mux with no register.
- `accum_bypass` has no effect on accumulation. The accumulator keeps integrating while the bypass is selected.
- Each `sN_out` = `sN_in` bit-for-bit. These paths are purely combinational, independent of `clk` and `rst_n`, with no inversion or reordering.
- The pass-through channels are independent of each other and of the accumulator.
- No X-generation is allowed: every output is defined from inputs and state at all times after the first reset.
- There is no other state. There are no handshakes, and all inputs are valid every cycle.

## Timing
- `accum_out`: 1-cycle latency. The value present after edge n equals the value before edge n plus the `accum_in` sampled at edge n.
- `accum_bypass_out` in bypass mode: 0-cycle, combinational from `accum_in`.
- `accum_bypass_out` in normal mode: follows `acc`.
- All `sN_out`: 0-cycle, combinational from the matching `sN_in`. A value driven before an edge is observable at that same edge.
- Reset values after the reset edge:
  - `accum_out` = 0.
  - `accum_bypass_out` = `accum_in` if bypass is selected, else 0.
  - Pass-through outputs are unaffected by reset.
- Reset mid-operation: the accumulated sum is discarded at the reset edge. Accumulation restarts from 0 at the first edge with `rst_n`=1.
- `accum_bypass` toggling: the output switches source in the same cycle. It causes no glitch in `acc`.
- Wrap example: `acc`=0xFFFF_FFFE with `accum_in`=5 gives `acc`=0x0000_0003 after the edge.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 edges with `accum_in`=0x1234 -> `accum_out`=0 after each edge, and `accum_bypass_out`=0 with bypass=0.
- **Accumulate:** release reset; drive `accum_in`=0, 5, 10, 15 on successive edges -> `accum_out`=0, 5, 15, 30. Then start `accum_in` at 100, incrementing by 5 per cycle, with the bench model `expect` <= `expect` + `accum_in` -> `accum_out` matches `expect` every cycle.
- **Bypass:** `accum_bypass`=1 with `accum_in`=0x55 -> `accum_bypass_out`=0x55 in the same cycle while `accum_out` keeps accumulating. Then drop bypass -> `accum_bypass_out`=`accum_out` immediately.
- **Wrap-around:** preload via accumulation to 0xFFFF_FFFE, then `accum_in`=5 -> `accum_out`=0x0000_0003.
- **Pass-throughs:** drive random values every cycle on s1, s2, s8, s33, s64, s65, s129 and s4x32, including all-ones, all-zeros, and a single 1 in the MSB of s65 and s129 -> each `*_out` equals its `*_in` at the next edge check.
- **Two instances:** run two instances with different `accum_in` seeds (0 and 100) -> each `accum_out` tracks only its own inputs; no cross-talk.
